// File: rtl/data_mem_pkg.sv
// Shared definitions for the data_mem arbiter: sign_mask codes, FSM states
// and the access alignment rule.
package data_mem_pkg;

    localparam logic [3:0] SM_BYTE   = 4'b0001;
    localparam logic [3:0] SM_HALF   = 4'b0011;
    localparam logic [3:0] SM_WORD   = 4'b0111;
    localparam logic [3:0] SM_SIGNED = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arb_state_t;

    // Unknown size codes are reported as misaligned so they never reach memory.
    function automatic logic is_misaligned(input logic [3:0] sign_mask,
                                           input logic [1:0] addr_lsb);
        logic [3:0] size_code;
        size_code = sign_mask & ~SM_SIGNED;
        case (size_code)
            SM_BYTE: is_misaligned = 1'b0;
            SM_HALF: is_misaligned = addr_lsb[0];
            SM_WORD: is_misaligned = |addr_lsb;
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_arbiter_rr.sv
// Two-way combinational round-robin grant: a lone requester always wins,
// on a tie the port that was not served last wins.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    // NOTE: every output of a combinational block gets a default first so
    // that no path through the case leaves it unassigned (no latch).
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer in front of data_mem.
// Optional WAIT timeout compiled in with `define DATA_MEM_ARB_TIMEOUT_EN.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [3:0]  req0_sign_mask,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp0_err,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req1_sign_mask,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        rsp1_err,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memread,
    output logic        mem_memwrite,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall,

    output logic        busy
);

    arb_state_t  state, state_next;
    logic        last_q;
    logic        port_q;
    logic        we_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic [1:0]  grant;
    logic        accept;
    logic        acc_port;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_sign_mask;
    logic        acc_misaligned;
    logic        timeout_hit;

    rr_arbiter2 u_rr (
        .valid (state == ST_IDLE ? {req1_valid, req0_valid} : 2'b00),
        .last  (last_q),
        .grant (grant)
    );

    assign accept = |grant;

    always_comb begin
        acc_port       = grant[1];
        acc_we         = acc_port ? req1_we        : req0_we;
        acc_addr       = acc_port ? req1_addr      : req0_addr;
        acc_wdata      = acc_port ? req1_wdata     : req0_wdata;
        acc_sign_mask  = acc_port ? req1_sign_mask : req0_sign_mask;
        acc_misaligned = is_misaligned(acc_sign_mask, acc_addr[1:0]);
    end

`ifdef DATA_MEM_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wait_cnt;

    // Cleared while in ISSUE so the count starts at zero on the first WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = (wait_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, TIMEOUT_W};
    assign timeout_hit        = 1'b0;
`endif

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes decode from the state register alone, so they fall with reset.
    always_comb begin
        state_next   = state;
        mem_memread  = 1'b0;
        mem_memwrite = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = acc_misaligned ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_memread  = !we_q;
                mem_memwrite = we_q;
                state_next   = ST_WAIT;
            end
            ST_WAIT: begin
                if (!mem_clk_stall || timeout_hit) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: every datapath flop, including the memory-facing operand
    // registers, has an explicit reset value so outputs are defined after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q         <= 1'b1;
            port_q         <= 1'b0;
            we_q           <= 1'b0;
            err_q          <= 1'b0;
            rdata_q        <= '0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_sign_mask  <= '0;
        end else begin
            if (accept) begin
                last_q  <= acc_port;
                port_q  <= acc_port;
                we_q    <= acc_we;
                err_q   <= acc_misaligned;
                rdata_q <= '0;
                // Misaligned requests never touch the memory bus.
                if (!acc_misaligned) begin
                    mem_addr       <= acc_addr;
                    mem_write_data <= acc_wdata;
                    mem_sign_mask  <= acc_sign_mask;
                end
            end
            if (state == ST_WAIT) begin
                if (!mem_clk_stall) begin
                    if (!we_q) begin
                        rdata_q <= mem_read_data;
                    end
                end else if (timeout_hit) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign busy       = (state != ST_IDLE);
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    assign rsp0_valid = (state == ST_RESP) && !port_q;
    assign rsp1_valid = (state == ST_RESP) &&  port_q;
    assign rsp0_err   = rsp0_valid & err_q;
    assign rsp1_err   = rsp1_valid & err_q;
    assign rsp0_rdata = rsp0_valid ? rdata_q : '0;
    assign rsp1_rdata = rsp1_valid ? rdata_q : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed vector table, grant
// alternation, reset mid-access, random traffic and the WAIT timeout.
module tb_data_mem_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sm;
    } req_t;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sm;
        int          stall;
        logic [31:0] mem_val;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_we;
    logic [31:0] req0_addr, req0_wdata;
    logic [3:0]  req0_sign_mask;
    logic        rsp0_valid, rsp0_err;
    logic [31:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [31:0] req1_addr, req1_wdata;
    logic [3:0]  req1_sign_mask;
    logic        rsp1_valid, rsp1_err;
    logic [31:0] rsp1_rdata;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_memread, mem_memwrite, mem_clk_stall;
    logic [3:0]  mem_sign_mask;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int last_served = 1;

    // Memory model: a strobe starts a stall of stall_len cycles.
    int          stall_len = 0;
    int          stall_cnt;
    logic [31:0] mem_rd_value = '0;

    data_mem_arbiter #(.TIMEOUT_CYCLES(8), .TIMEOUT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_sign_mask(req0_sign_mask),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_sign_mask(req1_sign_mask),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
        .mem_clk_stall(mem_clk_stall), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            stall_cnt <= 0;
        else if (mem_memread || mem_memwrite)  stall_cnt <= stall_len;
        else if (stall_cnt > 0)                stall_cnt <= stall_cnt - 1;
    end
    assign mem_clk_stall = (stall_cnt > 0);
    assign mem_read_data = mem_rd_value;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Alignment from access size in bytes; unknown codes are illegal.
    function automatic bit ref_misaligned(input logic [3:0] sm, input logic [31:0] addr);
        int size;
        case (sm[2:0])
            3'b001:  size = 1;
            3'b011:  size = 2;
            3'b111:  size = 4;
            default: size = 0;
        endcase
        return (size == 0) || ((addr % size) != 0);
    endfunction

    function automatic req_t rand_req();
        req_t r;
        logic [3:0] codes [8];
        logic [31:0] a;
        codes = '{4'b0001, 4'b0011, 4'b0111, 4'b1001, 4'b1011, 4'b1111, 4'b0000, 4'b0101};
        a       = $urandom;
        r.we    = 1'($urandom_range(0, 1));
        r.addr  = {a[31:2], 2'($urandom_range(0, 3))};
        r.wdata = $urandom;
        r.sm    = codes[$urandom_range(0, 7)];
        return r;
    endfunction

    task automatic drive_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        last_served = 1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Presents a request pattern, checks the grant, then follows the access
    // to its response. Starts and ends just after a falling edge.
    task automatic run_txn(input req_t r0, input bit v0, input req_t r1, input bit v1,
                           input int stall, input logic [31:0] mv, input bit hold,
                           input int exp_port, input logic exp_err,
                           input logic [31:0] exp_rdata, input int exp_lat);
        req_t er;
        bit   seen;
        int   lat;
        int   strobes;
        er = (exp_port == 1) ? r1 : r0;
        req0_valid = v0; req0_we = r0.we; req0_addr = r0.addr;
        req0_wdata = r0.wdata; req0_sign_mask = r0.sm;
        req1_valid = v1; req1_we = r1.we; req1_addr = r1.addr;
        req1_wdata = r1.wdata; req1_sign_mask = r1.sm;
        stall_len = stall;
        mem_rd_value = mv;
        #1;
        check("ready0", req0_ready, exp_port == 0);
        check("ready1", req1_ready, exp_port == 1);
        @(posedge clk);
        #1;
        if (!hold) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        req0_addr = $urandom; req0_wdata = $urandom; req0_we = ~req0_we;
        req1_addr = $urandom; req1_wdata = $urandom; req1_we = ~req1_we;
        seen = 0; lat = 0; strobes = 0;
        for (int c = 1; c <= 200 && !seen; c++) begin
            @(negedge clk);
            if (mem_memread || mem_memwrite) begin
                strobes++;
                check("strobe_kind", mem_memwrite, er.we);
                check("strobe_one", mem_memread & mem_memwrite, 0);
                check("mem_addr", mem_addr, er.addr);
                check("mem_write_data", mem_write_data, er.wdata);
                check("mem_sign_mask", mem_sign_mask, er.sm);
            end
            if (rsp0_valid || rsp1_valid) begin
                seen = 1;
                lat = c;
            end
        end
        check("rsp_seen", seen, 1);
        if (seen) begin
            check("rsp_port", rsp1_valid, exp_port == 1);
            check("rsp_single", rsp0_valid & rsp1_valid, 0);
            check("rsp_err", (exp_port == 1) ? rsp1_err : rsp0_err, exp_err);
            check("rsp_rdata", (exp_port == 1) ? rsp1_rdata : rsp0_rdata, exp_rdata);
            check("rsp_other_quiet", (exp_port == 1) ? {rsp0_err, rsp0_rdata[30:0]}
                                                     : {rsp1_err, rsp1_rdata[30:0]}, 0);
            check("latency", lat, exp_lat);
            check("ready_while_busy", req0_ready | req1_ready, 0);
            check("busy_in_resp", busy, 1);
        end
        check("strobe_count", strobes, exp_err ? 0 : 1);
        @(negedge clk);
        check("idle_after_resp", busy, 0);
    endtask

    vec_t vecs [9];
    req_t idle_req;
    req_t r0, r1, rw;
    int   exp_port;
    bit   v0, v1, mis, seen;
    int   lat, stall;
    logic [31:0] mv, got_rdata;
    logic got_err;

    initial begin
        vecs[0] = '{0, 1'b1, 32'h40,  32'hAAAA_AAAA, 4'b0111, 5, 32'h0,         1'b0, 32'h0,         8};
        vecs[1] = '{1, 1'b0, 32'h400, 32'h0,         4'b1001, 0, 32'hFFFF_FFAA, 1'b0, 32'hFFFF_FFAA, 3};
        vecs[2] = '{0, 1'b0, 32'h101, 32'h0,         4'b0011, 0, 32'h5555_5555, 1'b1, 32'h0,         1};
        vecs[3] = '{1, 1'b1, 32'h102, 32'h1234,      4'b0111, 0, 32'h0,         1'b1, 32'h0,         1};
        vecs[4] = '{0, 1'b0, 32'h0,   32'h0,         4'b0101, 0, 32'h7777_7777, 1'b1, 32'h0,         1};
        vecs[5] = '{1, 1'b0, 32'h8,   32'h0,         4'b0111, 2, 32'h1234_5678, 1'b0, 32'h1234_5678, 5};
        vecs[6] = '{0, 1'b0, 32'h3,   32'h0,         4'b0001, 1, 32'h0000_00C3, 1'b0, 32'h0000_00C3, 4};
        vecs[7] = '{1, 1'b1, 32'h22,  32'hBEEF,      4'b1011, 0, 32'hDEAD_0000, 1'b0, 32'h0,         3};
        vecs[8] = '{0, 1'b0, 32'h7FC, 32'h0,         4'b1111, 3, 32'h89AB_CDEF, 1'b0, 32'h89AB_CDEF, 6};
        idle_req = '{1'b0, 32'h0, 32'h0, 4'b0000};

        req0_we = 0; req0_addr = 0; req0_wdata = 0; req0_sign_mask = 0;
        req1_we = 0; req1_addr = 0; req1_wdata = 0; req1_sign_mask = 0;
        drive_reset();
        #1;
        check("rst_busy", busy, 0);
        check("rst_ready", {req0_ready, req1_ready}, 0);
        check("rst_strobes", {mem_memread, mem_memwrite}, 0);
        check("rst_rsp", {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}, 0);
        check("rst_rdata", rsp0_rdata | rsp1_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_write_data, 0);
        check("rst_mem_sm", mem_sign_mask, 0);
        release_reset();

        // Directed vector table, one port at a time.
        for (int i = 0; i < 9; i++) begin
            rw = '{vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sm};
            run_txn(vecs[i].port == 0 ? rw : idle_req, vecs[i].port == 0,
                    vecs[i].port == 1 ? rw : idle_req, vecs[i].port == 1,
                    vecs[i].stall, vecs[i].mem_val, 1'b0, vecs[i].port,
                    vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_lat);
            last_served = vecs[i].port;
        end

        // Both ports valid continuously from reset: grants go 0,1,0,1.
        drive_reset();
        release_reset();
        r0 = '{1'b0, 32'h100, 32'h0, 4'b0111};
        r1 = '{1'b0, 32'h200, 32'h0, 4'b0111};
        for (int k = 0; k < 4; k++) begin
            run_txn(r0, 1'b1, r1, 1'b1, 0, 32'hC0DE_0000 + k, 1'b1, k % 2,
                    1'b0, 32'hC0DE_0000 + k, 3);
        end
        last_served = 1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Reset during ISSUE: the write strobe must drop without a clock edge.
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h80;
        req0_wdata = 32'h1111_2222; req0_sign_mask = 4'b0111;
        stall_len = 1000;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        check("issue_strobe", mem_memwrite, 1);
        drive_reset();
        #1;
        check("rst_issue_strobe", mem_memwrite | mem_memread, 0);
        check("rst_issue_busy", busy, 0);
        release_reset();

        // Reset during WAIT, then a normal access completes.
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h84; req1_sign_mask = 4'b0111;
        stall_len = 1000;
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        @(posedge clk);
        #2;
        check("wait_busy", busy, 1);
        drive_reset();
        #1;
        check("rst_wait_strobes", {mem_memread, mem_memwrite}, 0);
        check("rst_wait_busy", busy, 0);
        check("rst_wait_rsp", {rsp0_valid, rsp1_valid}, 0);
        check("rst_wait_mem_addr", mem_addr, 0);
        release_reset();
        r1 = '{1'b0, 32'h90, 32'h0, 4'b0111};
        run_txn(idle_req, 1'b0, r1, 1'b1, 1, 32'h600D_F00D, 1'b0, 1, 1'b0, 32'h600D_F00D, 4);
        last_served = 1;

        // Random traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            int v;
            v  = $urandom_range(1, 3);
            v0 = v[0];
            v1 = v[1];
            r0 = rand_req();
            r1 = rand_req();
            stall = $urandom_range(0, 4);
            mv = $urandom;
            if (v0 && v1) exp_port = (last_served == 0) ? 1 : 0;
            else          exp_port = v0 ? 0 : 1;
            rw  = (exp_port == 1) ? r1 : r0;
            mis = ref_misaligned(rw.sm, rw.addr);
            run_txn(r0, v0, r1, v1, stall, mv, 1'b0, exp_port, mis,
                    (mis || rw.we) ? 32'h0 : mv, mis ? 1 : 3 + stall);
            last_served = exp_port;
        end

        // Stall held high indefinitely.
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h10; req1_sign_mask = 4'b0111;
        stall_len = 100000;
        mem_rd_value = 32'hFFFF_0000;
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        seen = 0; lat = 0; got_err = 0; got_rdata = 0;
        for (int c = 1; c <= 100 && !seen; c++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) begin
                seen = 1;
                lat = c;
                got_err = rsp1_err;
                got_rdata = rsp1_rdata;
            end
        end
`ifdef DATA_MEM_ARB_TIMEOUT_EN
        check("timeout_seen", seen, 1);
        check("timeout_latency", lat, 10);
        check("timeout_err", got_err, 1);
        check("timeout_rdata", got_rdata, 0);
`else
        check("no_timeout_seen", seen, 0);
        check("no_timeout_busy", busy, 1);
`endif
        drive_reset();
        #1;
        check("final_rst_busy", busy, 0);
        release_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and access sequencer in front of `data_mem`. It accepts load/store requests from the core (port 0) and the debug/DMA port (port 1) and grants them round-robin. It drives `data_mem` with a single-cycle `memread`/`memwrite` pulse and holds the operands stable while `clk_stall` is high. It then returns read data, or a write acknowledge, to the granted requester.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum WAIT cycles with stall high before abort; only used with `DATA_MEM_ARB_TIMEOUT_EN`.
- `TIMEOUT_W`, default 8: width of the timeout counter; must satisfy `2**TIMEOUT_W > TIMEOUT_CYCLES`.
- `clk`  in  1  the single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `reqN_valid`  in  1  request from port N (N = 0, 1).
- `reqN_ready`  out  1  port N request accepted when `valid & ready`.
- `reqN_we`  in  1  1 = store, 0 = load.
- `reqN_addr`  in  32  byte address.
- `reqN_wdata`  in  32  store data, LSB-aligned.
- `reqN_sign_mask`  in  4  size and sign code (see Operation).
- `rspN_valid`  out  1  one-cycle completion pulse.
- `rspN_rdata`  out  32  load result, valid with `rspN_valid`; 0 for stores.
- `rspN_err`  out  1  misaligned access or timeout, valid with `rspN_valid`.
- `mem_addr`, `mem_write_data`  out  32 each  driven to `data_mem` `addr` / `write_data`.
- `mem_memread`, `mem_memwrite`  out  1 each  access strobes.
- `mem_sign_mask`  out  4  driven to `data_mem` `sign_mask`.
- `mem_read_data`  in  32  from `data_mem` `read_data`.
- `mem_clk_stall`  in  1  from `data_mem` `clk_stall`; high = access in progress.
- `busy`  out  1  FSM not in IDLE.

## Operation
- `sign_mask` encoding:
  - 4'b0001 byte, 4'b0011 halfword, 4'b0111 word.
  - bit 3 = sign-extend on load.
  - Other codes are treated as misaligned (error).
- FSM states IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `reqN_ready` is combinational: high only for the granted port, and only when that port is valid.
  - If one port is valid, that port is granted.
  - If both are valid, the port not served last is granted. The `last` pointer resets to 1, so port 0 wins the first tie.
  - On accept, latch we/addr/wdata/sign_mask and the port id, then update `last`.
  - A misaligned request (half with addr[0]=1, word with addr[1:0]≠0, or an illegal code) goes directly to RESP with err=1 and no memory access.
- **ISSUE** (exactly 1 cycle): `mem_memread = !we` or `mem_memwrite = we` is high.
- **WAIT**
  - Strobes are low.
  - Stay while `mem_clk_stall` = 1.
  - On the first WAIT cycle with stall = 0, capture `mem_read_data` (loads) into the response register and go to RESP.
- **RESP** (1 cycle): `rspN_valid` = 1 for the latched port only, then return to IDLE.
- `mem_addr`, `mem_write_data` and `mem_sign_mask` are registered. They are held from ISSUE through RESP and keep their last value in IDLE.
- The block does no data manipulation: extension and masking are done by `data_mem`.

## Timing
- Reset values:
  - State IDLE; `last` = 1.
  - All `ready`, `rsp*_valid`, `rsp*_err`, strobes and `busy` = 0.
  - `rsp*_rdata`, `mem_addr`, `mem_write_data` = 0; `mem_sign_mask` = 0.
- Accept at cycle T:
  - T+1 ISSUE.
  - T+2 is the first WAIT cycle.
  - If stall is low at T+2, RESP at T+3. Minimum latency from accept to `rsp_valid` is 3 cycles.
- Misaligned request: `rsp_valid` at T+1.
- Throughput: at most one access per 4 cycles; `ready` is low on both ports while `busy`.
- A requester may deassert `valid` before acceptance without effect. Request fields only need to be stable in the accept cycle.
- Reset asserted mid-operation: outputs clear immediately (strobes drop asynchronously) and any in-flight response is lost.

## Configuration
- `DATA_MEM_ARB_TIMEOUT_EN` defined:
  - A WAIT-cycle counter is compiled in and cleared on entering WAIT.
  - If stall is still high after `TIMEOUT_CYCLES` WAIT cycles, go to RESP with err=1 and rdata=0.
- Not defined: WAIT is unbounded, `rspN_err` reports misalignment only, and the `TIMEOUT_*` parameters are unused.

## Structure
- Shared package `data_mem_pkg`:
  - `sign_mask` localparams: SM_BYTE, SM_HALF, SM_WORD, SM_SIGNED.
  - FSM state enum `arb_state_t`.
  - Alignment-check function.
- One sub-module: `rr_arbiter2`, combinational 2-way grant from valids and the `last` pointer.

## Test plan
- Port 0 stores word 0xAAAAAAAA at 0x40; memory model stalls 5 cycles:
  - `mem_memwrite` high for exactly 1 cycle.
  - `rsp0_valid` 1 cycle after stall drops, err=0.
- Port 1 signed-byte load (4'b1001) at 0x400, memory returns 0xFFFFFFAA → `rsp1_rdata` = 0xFFFFFFAA with no stall; latency is 3 cycles.
- Both ports valid continuously → grants alternate 0,1,0,1; no port is served twice in a row.
- Halfword load at 0x101 → `rsp_err` = 1 at T+1; `mem_memread` never asserts.
- Reset (`rst_n` low) during WAIT → strobes and `busy` are 0 immediately; after release, a new request completes normally.
- With `DATA_MEM_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8, stall held high → err response after 8 WAIT cycles; without the macro, still waiting at 100 cycles.
